// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: IF/ID/EXE/MEM/WB sequencing with a memory wait-state watchdog.
// Control outputs are decoded from the current state and op/funct; reset forces every output low.
module mc_ctrl_fsm #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       upover,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       i_or_d,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctr,
  output logic       ext_op,
  output logic       illegal,
  output logic       ovf_trap,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;

  state_t     r_state, w_next;
  logic [7:0] r_wait_cnt, w_wait_nxt;
  logic       r_ovf_q;

  logic w_rtype, w_add, w_sub, w_slt, w_ori, w_lw, w_sw, w_beq, w_j, w_legal;
  logic w_mem_phase, w_wd_exp;

  assign w_rtype = (op == OP_R);
  assign w_add   = w_rtype && (funct == F_ADD);
  assign w_sub   = w_rtype && (funct == F_SUB);
  assign w_slt   = w_rtype && (funct == F_SLT);
  assign w_ori   = (op == OP_ORI);
  assign w_lw    = (op == OP_LW);
  assign w_sw    = (op == OP_SW);
  assign w_beq   = (op == OP_BEQ);
  assign w_j     = (op == OP_J);
  assign w_legal = w_add || w_sub || w_slt || w_ori || w_lw || w_sw || w_beq || w_j;

  // The expiry cycle itself is a dedicated abort cycle: request dropped, no writes.
  assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
  assign w_wd_exp    = w_mem_phase && (r_wait_cnt == 8'(WAIT_LIMIT));

  assign state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IF;
      r_wait_cnt <= '0;
      r_ovf_q    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_ovf_q    <= (r_state == S_EXE) && w_add && upover;
    end
  end

  always_comb begin
    w_wait_nxt = '0;
    if (w_mem_phase && !w_wd_exp && !mem_ready && (w_next == r_state))
      w_wait_nxt = r_wait_cnt + 8'd1;
  end

  always_comb begin
    w_next     = r_state;
    pc_wr      = 1'b0;
    pc_src     = 2'b00;
    ir_wr      = 1'b0;
    i_or_d     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctr    = 2'b00;
    ext_op     = 1'b0;
    illegal    = 1'b0;
    ovf_trap   = 1'b0;
    bus_err    = 1'b0;
    if (rst) begin
      case (r_state)
        S_IF: begin
          alu_src_b = 2'b01;
          if (w_wd_exp) begin
            bus_err = 1'b1;
            w_next  = S_IF;
          end else begin
            mem_rd = 1'b1;
            if (mem_ready) begin
              ir_wr  = 1'b1;
              pc_wr  = 1'b1;
              w_next = S_ID;
            end
          end
        end
        S_ID: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
          if (w_j) begin
            pc_wr  = 1'b1;
            pc_src = 2'b10;
            w_next = S_IF;
          end else if (!w_legal) begin
            illegal = 1'b1;
            w_next  = S_IF;
          end else begin
            w_next = S_EXE;
          end
        end
        S_EXE: begin
          alu_src_a = 1'b1;
          w_next    = S_IF;
          if (w_rtype) begin
            alu_src_b = 2'b00;
            alu_ctr   = w_sub ? 2'b01 : (w_slt ? 2'b11 : 2'b00);
            w_next    = S_WB;
          end else if (w_ori) begin
            alu_src_b = 2'b10;
            alu_ctr   = 2'b10;
            w_next    = S_WB;
          end else if (w_lw || w_sw) begin
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            w_next    = S_MEM;
          end else if (w_beq) begin
            alu_src_b = 2'b00;
            alu_ctr   = 2'b01;
            pc_src    = 2'b01;
            pc_wr     = zero;
          end
        end
        S_MEM: begin
          i_or_d = 1'b1;
          if (w_wd_exp) begin
            bus_err = 1'b1;
            w_next  = S_IF;
          end else begin
            mem_rd = w_lw;
            mem_wr = w_sw;
            if (mem_ready) w_next = w_lw ? S_WB : S_IF;
          end
        end
        S_WB: begin
          reg_dst    = w_rtype;
          mem_to_reg = w_lw;
          reg_wr     = !r_ovf_q;
          ovf_trap   = r_ovf_q;
          w_next     = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle control unit for the MIPS multi-cycle CPU. It sequences the shared 2-bit-controlled ALU (00 add, 01 sub, 10 or, 11 slt) and the PC, IR, memory and register file across IF/ID/EXE/MEM/WB states. It samples the ALU zero and upover flags, and handles memory wait-states with a watchdog.

Parameters:
WAIT_LIMIT, 15, max consecutive cycles with mem_ready=0 in IF or MEM before bus_err is raised (1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
op  input  6  IR[31:26]; valid from ID onward
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
upover  input  1  ALU add-overflow flag
mem_ready  input  1  memory access completes this cycle
pc_wr  output  1  PC write enable
pc_src  output  2  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target
ir_wr  output  1  IR write enable
i_or_d  output  1  memory address: 0 PC, 1 ALUOut
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
reg_wr  output  1  register-file write enable
reg_dst  output  1  write register: 0 rt, 1 rd
mem_to_reg  output  1  write data: 0 ALUOut, 1 MDR
alu_src_a  output  1  0 PC, 1 register A
alu_src_b  output  2  00 register B, 01 const 4, 10 ext imm, 11 ext imm<<2
alu_ctr  output  2  ALU operation
ext_op  output  1  0 zero-extend, 1 sign-extend
illegal  output  1  one-cycle pulse: unsupported op/funct
ovf_trap  output  1  one-cycle pulse: add overflow, write suppressed
bus_err  output  1  one-cycle pulse: watchdog expired
state  output  3  current state, for debug

Behaviour:
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4. Reset state is IF.
- On reset (rst=0): all outputs 0; ovf_q=0; wait counter=0.
- Supported instructions:
  - R-type (op=000000): funct 100000 add, 100010 sub, 101010 slt
  - ori 001101, lw 100011, sw 101011, beq 000100, j 000010
- IF:
  - Outputs: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctr=00.
  - While mem_ready=0: stay in IF; ir_wr=0, pc_wr=0.
  - When mem_ready=1: ir_wr=1, pc_wr=1, pc_src=00, go to ID.
- ID:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_ctr=00, ext_op=1 (branch target into ALUOut).
  - j: pc_wr=1, pc_src=10, go to IF.
  - Unsupported op, or R-type with unknown funct: illegal=1, no writes, go to IF.
  - Otherwise go to EXE.
- EXE (alu_src_a=1):
  - R-type: alu_src_b=00; alu_ctr = 00 add / 01 sub / 11 slt.
  - ori: alu_src_b=10, ext_op=0, alu_ctr=10.
  - lw/sw: alu_src_b=10, ext_op=1, alu_ctr=00.
  - beq: alu_src_b=00, alu_ctr=01, pc_src=01, pc_wr=zero; go to IF.
  - ovf_q <= upover only for R-type add; otherwise ovf_q <= 0.
  - R-type and ori go to WB; lw and sw go to MEM.
- MEM:
  - Outputs: i_or_d=1; lw: mem_rd=1; sw: mem_wr=1.
  - Hold until mem_ready=1.
  - lw then goes to WB; sw then goes to IF.
- WB:
  - R-type: reg_dst=1, mem_to_reg=0. ori: reg_dst=0, mem_to_reg=0. lw: reg_dst=0, mem_to_reg=1.
  - reg_wr = !ovf_q. ovf_trap = ovf_q.
  - Go to IF.
- Latency in cycles with mem_ready always 1: j=2, beq=3, R-type/ori/sw=4, lw=5.
- Watchdog:
  - Counter increments each cycle in IF or MEM while mem_ready=0; clears on mem_ready=1 or on state change.
  - When the count reaches WAIT_LIMIT: bus_err=1 for one cycle; mem_rd and mem_wr drop; no PC or IR write; counter clears; go to IF.
  - If this happens in IF, the fetch restarts at the same PC.
- Control outputs are Moore-style from state plus op/funct. The only gated exceptions are pc_wr/ir_wr (by mem_ready, IF), pc_wr (by zero, EXE beq), and reg_wr (by ovf_q, WB).
- Pulse outputs (illegal, ovf_trap, bus_err) last exactly one cycle.
- Reset asserted mid-instruction: immediate return to IF; no write enable may remain high.

Test Plan:
- Reset release, mem_ready=1, op=000000/funct=100000 -> states 0,1,2,4,0. ir_wr and pc_wr high in cycle 0 only; alu_ctr=00 in EXE; reg_wr=1, reg_dst=1 in WB.
- lw with mem_ready low for 3 MEM cycles -> MEM held 4 cycles, mem_rd=1, i_or_d=1 throughout. WB: mem_to_reg=1, reg_wr=1. Total 8 cycles.
- beq, zero=1 -> EXE: alu_ctr=01, pc_wr=1, pc_src=01. Repeat with zero=0 -> pc_wr=0. Both return to IF after 3 cycles.
- add with upover=1 in EXE -> WB: reg_wr=0, ovf_trap=1 for one cycle. Next sub with upover=1 -> reg_wr=1, no trap.
- op=111111, then R-type funct=000001 -> illegal pulses in ID, no write enables, next state IF. j -> pc_src=10 in ID, 2 cycles total.
- WAIT_LIMIT=4, mem_ready held 0 in IF -> bus_err after 4 waiting cycles, pc_wr/ir_wr never high. Pulling rst low in MEM of sw -> mem_wr drops immediately, state=0.
